// File: rtl/rst_seq_synch.sv
// Reset synchroniser and sequencer: async assert, staged sync release
// of CHANNELS reset domains with stretch, gap, sw request and cause.
`timescale 1ns/1ps
module rst_seq_synch #(
    parameter int STAGES   = 2,
    parameter int CHANNELS = 4,
    parameter int STRETCH  = 0,
    parameter int GAP      = 16,
    parameter int NEGEDGE  = 1
) (
    input  logic                clk,
    input  logic                RST_n,
    input  logic                sw_rst_req,
    output logic [CHANNELS-1:0] rst_n,
    output logic                all_released,
    output logic [1:0]          rst_cause
);

    localparam int MAXV = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CW   = (MAXV < 1) ? 1 : $clog2(MAXV + 1);

    localparam logic [CW-1:0] STR_FULL = CW'(STRETCH);
    localparam logic [CW-1:0] STR_M1   =
        (STRETCH == 0) ? '0 : CW'(STRETCH - 1);
    localparam logic [CW-1:0] GAP_M1   = CW'(GAP - 1);
    localparam bit            NO_STR   = (STRETCH == 0);

    typedef enum logic [1:0] {
        S_RESET,
        S_STRETCH,
        S_RELEASE,
        S_RUN
    } state_t;

    logic                aclk;
    logic [STAGES-1:0]   sync_q;
    logic                sync_ok;
    logic                sync_pre;
    logic                sw_hit;
    logic                step;
    logic [CHANNELS-1:0] fill;
    logic                fill_last;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CHANNELS-1:0] rn_q, rn_d;
    logic                all_q, all_d;
    logic [1:0]          cause_q, cause_d;

    // Edge select: every flop runs on the rising edge of aclk.
    assign aclk = (NEGEDGE != 0) ? ~clk : clk;

    // Sync chain shifting in ones; async clear on RST_n.
    always_ff @(posedge aclk or negedge RST_n) begin
        if (!RST_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    // sync_pre is the D of the sync_ok flop, so RESET is left at the
    // very edge on which sync_ok rises (legacy E2 timing for STAGES=2).
    assign sync_ok  = sync_q[STAGES-1];
    assign sync_pre = sync_q[STAGES-2];

    // Next release pattern: one more bit filled from the bottom.
    generate
        if (CHANNELS == 1) begin : g_one
            assign fill = 1'b1;
        end else begin : g_many
            assign fill = {rn_q[CHANNELS-2:0], 1'b1};
        end
    endgenerate

    assign fill_last = fill[CHANNELS-1];

    assign sw_hit = sw_rst_req & sync_ok & (state_q != S_RESET);

    // FSM state, counter and registered outputs.
    always_ff @(posedge aclk or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            rn_q    <= '0;
            all_q   <= 1'b0;
            cause_q <= 2'b01;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rn_q    <= rn_d;
            all_q   <= all_d;
            cause_q <= cause_d;
        end
    end

    // Next-state: stretch, then one channel per GAP; sw request wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rn_d    = rn_q;
        all_d   = all_q;
        cause_d = cause_q;
        step    = 1'b0;

        unique case (state_q)
            S_RESET: begin
                if (sync_pre) begin
                    if (NO_STR) begin
                        step = 1'b1;
                    end else begin
                        state_d = S_STRETCH;
                        cnt_d   = STR_M1;
                    end
                end
            end
            S_STRETCH, S_RELEASE: begin
                if (cnt_q == '0) begin
                    step = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        if (step) begin
            rn_d = fill;
            if (fill_last) begin
                state_d = S_RUN;
                all_d   = 1'b1;
            end else begin
                state_d = S_RELEASE;
                cnt_d   = GAP_M1;
            end
        end

        // Full stretch value: the request edge itself is one low cycle.
        if (sw_hit) begin
            state_d = S_STRETCH;
            cnt_d   = STR_FULL;
            rn_d    = '0;
            all_d   = 1'b0;
            cause_d = 2'b10;
        end
    end

    assign rst_n        = rn_q;
    assign all_released = all_q;
    assign rst_cause    = cause_q;

endmodule

// File: tb/tb_rst_seq_synch.sv
// Bench for rst_seq_synch: scoreboard of expected outputs per edge,
// plus legacy single-channel instances on both clock edges.
`timescale 1ns/1ps
module tb_rst_seq_synch;

    logic       clk = 1'b0;
    logic       RST_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       sw_off = 1'b0;

    logic [2:0] rn;
    logic       all_r;
    logic [1:0] cs;
    logic [0:0] rn_l, rn_p;
    logic       all_l, all_p;
    logic [1:0] cs_l, cs_p;

    int total = 0;
    int bad   = 0;
    int ne    = 0;
    int pe    = 0;
    int bn, bp, s, l;

    typedef struct {
        int         dom;
        int         e;
        logic [2:0] rn;
        logic       all;
        logic [1:0] cs;
    } exp_t;

    exp_t q_n[$];
    exp_t q_p[$];

    always #5 clk = ~clk;

    rst_seq_synch #(
        .STAGES(2), .CHANNELS(3), .STRETCH(5),
        .GAP(4), .NEGEDGE(1)
    ) u_dut (
        .clk(clk), .RST_n(RST_n), .sw_rst_req(sw_rst_req),
        .rst_n(rn), .all_released(all_r), .rst_cause(cs)
    );

    rst_seq_synch #(
        .STAGES(2), .CHANNELS(1), .STRETCH(0),
        .GAP(16), .NEGEDGE(1)
    ) u_leg (
        .clk(clk), .RST_n(RST_n), .sw_rst_req(sw_off),
        .rst_n(rn_l), .all_released(all_l), .rst_cause(cs_l)
    );

    rst_seq_synch #(
        .STAGES(2), .CHANNELS(1), .STRETCH(0),
        .GAP(16), .NEGEDGE(0)
    ) u_pos (
        .clk(clk), .RST_n(RST_n), .sw_rst_req(sw_off),
        .rst_n(rn_p), .all_released(all_p), .rst_cause(cs_p)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int dom, input int e, input logic [2:0] r,
                        input logic a, input logic [1:0] c);
        exp_t x;
        x.dom = dom;
        x.e   = e;
        x.rn  = r;
        x.all = a;
        x.cs  = c;
        if (dom == 2) q_p.push_back(x);
        else          q_n.push_back(x);
    endtask

    // Main channel: releases at b+7, b+11, b+15 (b = edge before E1).
    task automatic push_nom(input int b, input logic [1:0] c);
        push(0, b + 6,  3'b000, 1'b0, c);
        push(0, b + 7,  3'b001, 1'b0, c);
        push(0, b + 10, 3'b001, 1'b0, c);
        push(0, b + 11, 3'b011, 1'b0, c);
        push(0, b + 14, 3'b011, 1'b0, c);
        push(0, b + 15, 3'b111, 1'b1, c);
    endtask

    task automatic push_leg(input int b_n, input int b_p);
        push(1, b_n + 1, 3'b000, 1'b0, 2'b01);
        push(1, b_n + 2, 3'b001, 1'b1, 2'b01);
        push(2, b_p + 1, 3'b000, 1'b0, 2'b01);
        push(2, b_p + 2, 3'b001, 1'b1, 2'b01);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q_n.size() != 0 || q_p.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk(tag, 8'(q_n.size() + q_p.size()), 8'd0);
    endtask

    // Falling-edge monitor: main and legacy-negedge instances.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            ne++;
            #1;
            for (int i = q_n.size() - 1; i >= 0; i--) begin
                if (q_n[i].e == ne) begin
                    x = q_n[i];
                    if (x.dom == 0) begin
                        chk($sformatf("rst_n@E%0d", x.e), 8'(rn), 8'(x.rn));
                        chk($sformatf("all@E%0d", x.e), 8'(all_r), 8'(x.all));
                        chk($sformatf("cause@E%0d", x.e), 8'(cs), 8'(x.cs));
                    end else begin
                        chk($sformatf("leg_rst@E%0d", x.e), 8'(rn_l), 8'(x.rn));
                        chk($sformatf("leg_all@E%0d", x.e), 8'(all_l), 8'(x.all));
                        chk($sformatf("leg_cause@E%0d", x.e), 8'(cs_l), 8'(x.cs));
                    end
                    q_n.delete(i);
                end
            end
        end
    end

    // Rising-edge monitor: legacy instance with NEGEDGE=0.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            pe++;
            #1;
            for (int i = q_p.size() - 1; i >= 0; i--) begin
                if (q_p[i].e == pe) begin
                    x = q_p[i];
                    chk($sformatf("pos_rst@P%0d", x.e), 8'(rn_p), 8'(x.rn));
                    chk($sformatf("pos_all@P%0d", x.e), 8'(all_p), 8'(x.all));
                    q_p.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 RST_n = 1'b0;
        #1;
        chk("rst_rst_n", 8'(rn), 8'h00);
        chk("rst_all", 8'(all_r), 8'h00);
        chk("rst_cause", 8'(cs), 8'h01);
        chk("rst_leg", 8'(rn_l), 8'h00);
        chk("rst_pos", 8'(rn_p), 8'h00);
        chk("rst_leg_cause", 8'(cs_l), 8'h01);

        // Nominal release with an early sw request (ignored).
        repeat (3) @(negedge clk);
        #2;
        bn = ne;
        bp = pe;
        RST_n = 1'b1;
        sw_rst_req = 1'b1;
        push_nom(bn, 2'b01);
        push_leg(bn, bp);
        @(negedge clk);
        #2 sw_rst_req = 1'b0;
        drain("nominal");

        // Single-cycle sw request from RUN.
        @(negedge clk);
        #2;
        s = ne + 1;
        sw_rst_req = 1'b1;
        push(0, s, 3'b000, 1'b0, 2'b10);
        push_nom(s - 1, 2'b10);
        @(negedge clk);
        #2 sw_rst_req = 1'b0;
        drain("sw_single");

        // sw request held for 10 samples.
        @(negedge clk);
        #2;
        s = ne + 1;
        l = s + 9;
        sw_rst_req = 1'b1;
        push(0, s, 3'b000, 1'b0, 2'b10);
        push(0, s + 4, 3'b000, 1'b0, 2'b10);
        push(0, l, 3'b000, 1'b0, 2'b10);
        push_nom(l - 1, 2'b10);
        repeat (10) @(negedge clk);
        #2 sw_rst_req = 1'b0;
        drain("sw_held");

        // 3 ns glitch in RUN.
        @(negedge clk);
        #1 RST_n = 1'b0;
        #1;
        chk("glitch_rst_n", 8'(rn), 8'h00);
        chk("glitch_all", 8'(all_r), 8'h00);
        chk("glitch_cause", 8'(cs), 8'h01);
        chk("glitch_leg", 8'(rn_l), 8'h00);
        chk("glitch_pos", 8'(rn_p), 8'h00);
        #2;
        bn = ne;
        bp = pe;
        RST_n = 1'b1;
        push_nom(bn, 2'b01);
        push_leg(bn, bp);
        drain("glitch_rerun");

        // Abort at E9 + 2 ns, then full rerun.
        @(negedge clk);
        #2 RST_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        bn = ne;
        bp = pe;
        RST_n = 1'b1;
        push(0, bn + 6, 3'b000, 1'b0, 2'b01);
        push(0, bn + 7, 3'b001, 1'b0, 2'b01);
        push(0, bn + 9, 3'b001, 1'b0, 2'b01);
        push_leg(bn, bp);
        while (ne < bn + 9) @(negedge clk);
        #2 RST_n = 1'b0;
        #1;
        chk("abort_rst_n", 8'(rn), 8'h00);
        chk("abort_all", 8'(all_r), 8'h00);
        chk("abort_cause", 8'(cs), 8'h01);
        chk("abort_leg", 8'(rn_l), 8'h00);
        chk("abort_pos_all", 8'(all_p), 8'h00);
        @(negedge clk);
        @(negedge clk);
        #2;
        bn = ne;
        bp = pe;
        RST_n = 1'b1;
        push_nom(bn, 2'b01);
        push_leg(bn, bp);
        drain("abort_rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_synch.md
# rst_seq_synch

Parametrised reset synchroniser and sequencer, successor to the single-channel two-flop reset synchroniser. It takes the raw push-button/power-on reset, asserts every output asynchronously, and releases several synchronous reset domains one at a time with programmable spacing: motor drive, sensors, control, comms. It adds configurable synchroniser depth, a post-sync stretch interval, a software reset request, and a reset-cause register. It sits at the top level between the board reset pin and every block's `rst_n`.

## Interface
- `STAGES`, default 2: synchroniser flop count, legal range ≥2.
- `CHANNELS`, default 4: number of reset outputs, legal range 1..16.
- `STRETCH`, default 0: extra cycles held after synchronisation before channel 0 releases, legal range 0..65535.
- `GAP`, default 16: cycles between consecutive channel releases, legal range 1..65535.
- `NEGEDGE`, default 1: 1 = all flops clocked on falling `clk` (legacy behaviour); 0 = rising edge.
- `clk  input  1  system clock; "active edge" below means the edge selected by NEGEDGE`
- `RST_n  input  1  reset, asynchronous, active-low`
- `sw_rst_req  input  1  synchronous software reset request, sampled at active edges`
- `rst_n  output  CHANNELS  per-domain reset, active-low, registered; bit 0 releases first`
- `all_released  output  1  high when every rst_n bit is high`
- `rst_cause  output  2  01 = last reset from RST_n, 10 = last reset from sw_rst_req; 00 and 11 are never driven`

## Operation
- RST_n low (any duration, any phase) asynchronously clears:
  - the sync chain, all `rst_n` bits, `all_released`, and the counters;
  - the FSM, to RESET.
- It also asynchronously sets `rst_cause` = 01. No clock is required for assertion.
- Sync chain: STAGES flops, first D tied to 1. The last flop is `sync_ok`. Deassertion reaches the FSM only through `sync_ok`.
- FSM states and transitions:
  - **RESET**: outputs all 0. Leave when `sync_ok` = 1.
  - **STRETCH**: count STRETCH cycles. With STRETCH = 0, RESET passes straight to RELEASE behaviour on the same edge.
  - **RELEASE**: set `rst_n[k]`, then wait GAP cycles, then set `rst_n[k+1]`. After `rst_n[CHANNELS-1]` is set, go to RUN.
  - **RUN**: `all_released` = 1; hold.
- Release is monotonic. A `rst_n` bit never returns to 0 except by RST_n or `sw_rst_req`.
- `sw_rst_req` = 1 at an active edge in STRETCH, RELEASE or RUN:
  - at that edge, all `rst_n` bits and `all_released` go to 0, and `rst_cause` goes to 10;
  - counters reload and the FSM enters STRETCH.
- `sw_rst_req` is ignored while `sync_ok` = 0.
- `sw_rst_req` held high restarts the sequence every cycle. Release timing counts from the last edge at which it was sampled high.
- Counters are sized to clog2(max(STRETCH, GAP) + 1) and never wrap. Each reloads on entering its interval.
- RST_n asserted mid-sequence or mid-stretch aborts everything immediately (async). The full sequence restarts from RESET on deassertion.

## Timing
Numbering: E1 is the first active edge after RST_n rises, E2 the next, and so on.
- Reset values:
  - `rst_n` = 0 on all bits;
  - `all_released` = 0;
  - `rst_cause` = 01;
  - `sync_ok` = 0.
- `sync_ok` rises at E_STAGES.
- `rst_n[0]` rises at E(STAGES+STRETCH).
- `rst_n[k]` rises at E(STAGES+STRETCH+k·GAP).
- `all_released` rises at the same edge as `rst_n[CHANNELS-1]`.
- For a software request sampled at edge Es:
  - all outputs are 0 after Es;
  - `rst_n[k]` rises at E(s+1+STRETCH+k·GAP), so the minimum low time is 1 cycle.
- With STAGES=2, CHANNELS=1, STRETCH=0, NEGEDGE=1, `rst_n[0]` rises at E2. This is cycle-identical to the legacy synchroniser.
- All outputs come straight from flops, so there is no combinational path from any input to any output.
- Assertion is asynchronous, with zero clock latency.

## Test plan
- **Nominal release.** Setup: STAGES=2, CHANNELS=3, STRETCH=5, GAP=4, NEGEDGE=1; deassert RST_n between edges. Required:
  - `rst_n[0]` rises at E7, `rst_n[1]` at E11, `rst_n[2]` at E15;
  - `all_released` rises at E15;
  - `rst_cause` = 01.
- **Mid-sequence abort.** Setup as above; pull RST_n low at E9 + ¼ cycle. Required:
  - `rst_n` = 000 and `all_released` = 0 within the same half-cycle, with no clock edge needed;
  - on re-release, the full sequence repeats: E7/E11/E15 relative to the new E1.
- **Short glitch.** Setup as above; RST_n low for 3 ns between edges while in RUN. Required:
  - all outputs 0 immediately;
  - full sequence restarts;
  - no partial release.
- **Software reset.** Setup as above; in RUN, pulse `sw_rst_req` for one cycle, sampled at Es. Required:
  - all `rst_n` bits 0 after Es;
  - `rst_cause` = 10;
  - `rst_n[0]` rises at E(s+6), `rst_n[1]` at E(s+10), `rst_n[2]` at E(s+14).
- **Held and early software reset.** Setup as above. Required:
  - `sw_rst_req` held high for 10 cycles: releases are timed from the last high sample;
  - `sw_rst_req` asserted before E2, while `sync_ok` = 0: ignored, `rst_cause` stays 01.
- **Legacy equivalence and edge select.** Setup: STAGES=2, CHANNELS=1, STRETCH=0, NEGEDGE=1. Required:
  - `rst_n[0]` rises at the 2nd falling edge after RST_n rises;
  - with NEGEDGE=0, it rises at the 2nd rising edge instead.
